pc_sequencer: RTL

Controller for the program-counter increment datapath: owns the PC register and drives the n-bit CLA adder to produce the next PC. It issues PCs to the instruction-fetch stage over a valid/ready handshake and arbitrates between sequential increment, branch redirect and halt. It sits between the fetch unit and the branch source and replaces free-running shift-register/adder increment with a stallable, redirectable sequence.

---
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the program counter and issues PCs to fetch over valid/ready,
// choosing between CLA increment, branch redirect (direct or pending) and halt.

module nbit_CLA_full_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign g[gi]   = a[gi] & b[gi];
      assign p[gi]   = a[gi] ^ b[gi];
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  // Each carry is the flattened lookahead sum-of-products, not a ripple chain.
  always_comb begin
    logic acc;
    logic prod;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = acc | (prod & cin);
    end
  end

  assign cout = c[WIDTH];
endmodule

module pc_sequencer #(
  parameter int             WIDTH    = 4,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             busy,
  output logic             wrap
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] inc_sum;
  logic             inc_carry;
  logic             accept;

  nbit_CLA_full_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (pc_q),
    .b    (STEP),
    .cin  (1'b0),
    .sum  (inc_sum),
    .cout (inc_carry)
  );

  assign accept = pc_valid & fetch_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !halt) state_d = ISSUE;
      ISSUE: begin
        if (halt && accept)       state_d = IDLE;
        else if (halt && !accept) state_d = DRAIN;
      end
      DRAIN:   if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_valid = (state_q == ISSUE) || (state_q == DRAIN);
    busy     = (state_q != IDLE);
  end

  // A live branch beats a pending one; only a plain increment may report wrap.
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    wrap_d        = 1'b0;
    if (accept) begin
      pend_valid_d = 1'b0;
      if (br_valid) begin
        pc_d = br_target;
      end else if (pend_valid_q) begin
        pc_d = pend_target_q;
      end else begin
        pc_d   = inc_sum;
        wrap_d = inc_carry;
      end
    end else if (br_valid) begin
      pend_valid_d  = 1'b1;
      pend_target_d = br_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      wrap_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      wrap_q        <= wrap_d;
    end
  end

  assign pc   = pc_q;
  assign wrap = wrap_q;
endmodule
